// File: rtl/xor_unit.sv
// Bitwise XOR leaf: combinational a ^ b plus a one-deep valid/ready register with parity and a saturating mismatch counter.
// Optional popcount output is enabled by defining XOR_UNIT_POPCOUNT_EN.
module xor_unit #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] c_q,
    output logic             parity_q,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef XOR_UNIT_POPCOUNT_EN
    output logic [$clog2(WIDTH+1)-1:0] popcnt_q,
`endif
    output logic [CNT_W-1:0] mismatch_cnt
);

    function automatic logic parity_of(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

`ifdef XOR_UNIT_POPCOUNT_EN
    localparam int PC_W = $clog2(WIDTH + 1);

    function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [PC_W-1:0] n;
        n = {PC_W{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    logic [PC_W-1:0] popcnt_r;
`endif

    logic [WIDTH-1:0] diff_s;
    logic             accept_s;
    logic             cnt_inc_s;
    logic [WIDTH-1:0] c_q_r;
    logic             parity_r;
    logic             valid_r;
    logic [CNT_W-1:0] cnt_r;

    // Handshake decode; the counter stops one short of wrapping.
    always_comb begin
        diff_s    = a ^ b;
        accept_s  = in_valid && (!valid_r || out_ready);
        cnt_inc_s = 1'b0;
        if (accept_s && (diff_s != {WIDTH{1'b0}}) && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_inc_s = 1'b1;
        end else begin
            cnt_inc_s = 1'b0;
        end
    end

    // Output stage: load on accept, drop valid on drain-only, hold on stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q_r    <= {WIDTH{1'b0}};
            parity_r <= 1'b0;
            valid_r  <= 1'b0;
        end else if (accept_s) begin
            c_q_r    <= diff_s;
            parity_r <= parity_of(diff_s);
            valid_r  <= 1'b1;
        end else if (out_ready) begin
            valid_r  <= 1'b0;
        end else begin
            valid_r  <= valid_r;
        end
    end

    // Saturating count of accepted pairs that differ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_inc_s) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

`ifdef XOR_UNIT_POPCOUNT_EN
    // Set-bit count of the accepted difference, held alongside c_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            popcnt_r <= {PC_W{1'b0}};
        end else if (accept_s) begin
            popcnt_r <= popcount(diff_s);
        end else begin
            popcnt_r <= popcnt_r;
        end
    end

    assign popcnt_q = popcnt_r;
`endif

    assign c            = diff_s;
    assign in_ready     = !valid_r || out_ready;
    assign c_q          = c_q_r;
    assign parity_q     = parity_r;
    assign out_valid    = valid_r;
    assign mismatch_cnt = cnt_r;

endmodule

// File: tb/tb_xor_unit.sv
// Scoreboard bench for xor_unit: a WIDTH=1/CNT_W=8 and a WIDTH=8/CNT_W=2 instance share one stimulus stream.
// Build with XOR_UNIT_POPCOUNT_EN defined to also check popcnt_q.
module tb_xor_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] a, b;
    logic       in_valid, out_ready;

    logic       c1, cq1, par1, ov1, rdy1;
    logic [7:0] cnt1;
    logic [7:0] c8, cq8;
    logic       par8, ov8, rdy8;
    logic [1:0] cnt8;
`ifdef XOR_UNIT_POPCOUNT_EN
    logic       pc1;
    logic [3:0] pc8;
`endif

    xor_unit #(.WIDTH(1), .CNT_W(8)) u_w1 (
        .clk(clk), .rst(rst), .a(a[0]), .b(b[0]), .c(c1),
        .in_valid(in_valid), .in_ready(rdy1), .c_q(cq1), .parity_q(par1),
        .out_valid(ov1), .out_ready(out_ready),
`ifdef XOR_UNIT_POPCOUNT_EN
        .popcnt_q(pc1),
`endif
        .mismatch_cnt(cnt1)
    );

    xor_unit #(.WIDTH(8), .CNT_W(2)) u_w8 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c8),
        .in_valid(in_valid), .in_ready(rdy8), .c_q(cq8), .parity_q(par8),
        .out_valid(ov8), .out_ready(out_ready),
`ifdef XOR_UNIT_POPCOUNT_EN
        .popcnt_q(pc8),
`endif
        .mismatch_cnt(cnt8)
    );

    typedef struct packed {
        logic [7:0] c;
        logic       par;
        logic [7:0] cnt;
        logic [3:0] pc;
    } exp_t;

    exp_t       q1[$], q8[$];
    exp_t       held1, held8;
    logic       m_ov;
    logic [7:0] m_cnt1;
    logic [1:0] m_cnt8;
    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] pa [5];
    logic [7:0] pb [5];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_ov   = 1'b0;
        m_cnt1 = 8'd0;
        m_cnt8 = 2'd0;
        held1  = '0;
        held8  = '0;
        q1.delete();
        q8.delete();
    endtask

    task automatic check_held();
        check_eq("out_valid_w1", 32'(ov1), 32'(m_ov));
        check_eq("out_valid_w8", 32'(ov8), 32'(m_ov));
        check_eq("c_q_w1", 32'(cq1), 32'(held1.c[0]));
        check_eq("parity_w1", 32'(par1), 32'(held1.par));
        check_eq("cnt_w1", 32'(cnt1), 32'(held1.cnt));
        check_eq("c_q_w8", 32'(cq8), 32'(held8.c));
        check_eq("parity_w8", 32'(par8), 32'(held8.par));
        check_eq("cnt_w8", 32'(cnt8), 32'(held8.cnt[1:0]));
`ifdef XOR_UNIT_POPCOUNT_EN
        check_eq("popcnt_w1", 32'(pc1), 32'(held1.pc[0]));
        check_eq("popcnt_w8", 32'(pc8), 32'(held8.pc));
`endif
    endtask

    // One clock of stimulus; called just after a rising edge.
    task automatic cycle(input logic [7:0] ta, input logic [7:0] tb_, input logic tv, input logic tr);
        logic       exp_rdy, acc, x1;
        logic [7:0] x8;
        exp_t       e;
        a = ta; b = tb_; in_valid = tv; out_ready = tr;
        #1;
        x8 = ta ^ tb_;
        x1 = ta[0] ^ tb_[0];
        check_eq("c_w8", 32'(c8), 32'(x8));
        check_eq("c_w1", 32'(c1), 32'(x1));
        exp_rdy = !m_ov || tr;
        check_eq("in_ready_w8", 32'(rdy8), 32'(exp_rdy));
        check_eq("in_ready_w1", 32'(rdy1), 32'(exp_rdy));
        acc = tv && exp_rdy;
        if (acc) begin
            if (x8 != 8'd0 && m_cnt8 != 2'd3) m_cnt8 = m_cnt8 + 2'd1;
            if (x1 && m_cnt1 != 8'hFF) m_cnt1 = m_cnt1 + 8'd1;
            q8.push_back('{c: x8, par: ^x8, cnt: {6'd0, m_cnt8}, pc: 4'($countones(x8))});
            q1.push_back('{c: {7'd0, x1}, par: x1, cnt: m_cnt1, pc: {3'd0, x1}});
            m_ov = 1'b1;
        end else if (tr) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
        if (acc) begin
            if (q8.size() == 0 || q1.size() == 0) begin
                check_eq("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                e = q8.pop_front(); held8 = e;
                e = q1.pop_front(); held1 = e;
            end
        end
        check_held();
    endtask

    // Assert reset between edges while the stage is holding data.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        check_held();
        check_eq("c_in_reset", 32'(c8), 32'(a ^ b));
        @(posedge clk);
        #1;
        check_held();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; a = 8'h00; b = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
        model_clear();
        pa[0] = 8'd0; pa[1] = 8'd0; pa[2] = 8'd1; pa[3] = 8'd0; pa[4] = 8'd1;
        pb[0] = 8'd0; pb[1] = 8'd1; pb[2] = 8'd0; pb[3] = 8'd1; pb[4] = 8'd1;
        #1;
        check_held();
        a = 8'h5A; b = 8'h0F;
        #1;
        check_eq("c_during_reset", 32'(c8), 32'h55);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 5; i++) cycle(pa[i], pb[i], 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(pa[i], pb[i], 1'b1, 1'b1);
        check_eq("stream_cnt_w1", 32'(cnt1), 32'd3);

        do_reset();

        cycle(8'hF0, 8'h0F, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(8'hAA, 8'hAA, 1'b1, 1'b0);
        check_eq("stall_c_q", 32'(cq8), 32'hFF);
        cycle(8'hAA, 8'hAA, 1'b1, 1'b1);
        check_eq("after_stall_cnt", 32'(cnt8), 32'd1);
        cycle(8'h00, 8'h00, 1'b0, 1'b1);

        do_reset();
        for (int i = 0; i < 5; i++) cycle(8'(i + 1), 8'h00, 1'b1, 1'b1);
        check_eq("saturated_cnt", 32'(cnt8), 32'd3);

        cycle(8'hFF, 8'h01, 1'b1, 1'b1);
        check_eq("ff01_parity", 32'(par8), 32'd1);

        for (int i = 0; i < 40; i++) begin
            cycle(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        end
        cycle(8'h00, 8'h00, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
